// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Holds the WB->ID bypass, load-use hazard detection and the bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] IF_ID_Rs,
  input  logic [REG_AW-1:0] IF_ID_Rt,
  input  logic [REG_AW-1:0] IF_ID_Rd,
  input  logic [IMM_W-1:0]  IF_ID_Imm,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic              Ctl_RegWrite,
  input  logic              Ctl_MemRead,
  input  logic              Ctl_MemWrite,
  input  logic              Ctl_MemToReg,
  input  logic              Ctl_ALUSrc,
  input  logic              Ctl_RegDst,
  input  logic [3:0]        Ctl_ALUOp,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_DstReg,
  input  logic [DATA_W-1:0] WB_Data,
  input  logic              Flush,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_MemToReg,
  output logic              ID_EX_ALUSrc,
  output logic              ID_EX_RegDst,
  output logic [3:0]        ID_EX_ALUOp,
  output logic [REG_AW-1:0] ID_EX_Rs,
  output logic [REG_AW-1:0] ID_EX_Rt,
  output logic [REG_AW-1:0] ID_EX_Rd,
  output logic [DATA_W-1:0] ID_EX_Data1,
  output logic [DATA_W-1:0] ID_EX_Data2,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic              Stall,
  output logic [CNT_W-1:0]  StallCount
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic              reg_dst;
    logic [3:0]        alu_op;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] imm;
  } id_ex_t;

  id_ex_t           ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] op1, op2;
  logic             hazard, stall;

  // WB writes on the same edge this stage captures, so the regfile value is stale.
  always_comb begin
    op1 = ReadData1;
    op2 = ReadData2;
    if (WB_RegWrite && (WB_DstReg != '0) && (WB_DstReg == IF_ID_Rs)) op1 = WB_Data;
    if (WB_RegWrite && (WB_DstReg != '0) && (WB_DstReg == IF_ID_Rt)) op2 = WB_Data;
  end

  always_comb begin
    hazard = ex_q.mem_read && (ex_q.rt != '0) &&
             ((ex_q.rt == IF_ID_Rs) || (ex_q.rt == IF_ID_Rt));
    stall  = hazard && !Flush;
  end

  // An all-zero register is a NOP, so flush and stall share one bubble.
  always_comb begin
    ex_d = '0;
    if (!Flush && !stall) begin
      ex_d.reg_write  = Ctl_RegWrite;
      ex_d.mem_read   = Ctl_MemRead;
      ex_d.mem_write  = Ctl_MemWrite;
      ex_d.mem_to_reg = Ctl_MemToReg;
      ex_d.alu_src    = Ctl_ALUSrc;
      ex_d.reg_dst    = Ctl_RegDst;
      ex_d.alu_op     = Ctl_ALUOp;
      ex_d.rs         = IF_ID_Rs;
      ex_d.rt         = IF_ID_Rt;
      ex_d.rd         = IF_ID_Rd;
      ex_d.data1      = op1;
      ex_d.data2      = op2;
      ex_d.imm        = {{(DATA_W-IMM_W){IF_ID_Imm[IMM_W-1]}}, IF_ID_Imm};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ID_EX_RegWrite = ex_q.reg_write;
  assign ID_EX_MemRead  = ex_q.mem_read;
  assign ID_EX_MemWrite = ex_q.mem_write;
  assign ID_EX_MemToReg = ex_q.mem_to_reg;
  assign ID_EX_ALUSrc   = ex_q.alu_src;
  assign ID_EX_RegDst   = ex_q.reg_dst;
  assign ID_EX_ALUOp    = ex_q.alu_op;
  assign ID_EX_Rs       = ex_q.rs;
  assign ID_EX_Rt       = ex_q.rt;
  assign ID_EX_Rd       = ex_q.rd;
  assign ID_EX_Data1    = ex_q.data1;
  assign ID_EX_Data2    = ex_q.data2;
  assign ID_EX_Imm      = ex_q.imm;
  assign Stall          = stall;
  assign StallCount     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; counter narrowed to 2 bits to reach saturation.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int IMM_W  = 16;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] IF_ID_Rs, IF_ID_Rt, IF_ID_Rd;
  logic [IMM_W-1:0]  IF_ID_Imm;
  logic [DATA_W-1:0] ReadData1, ReadData2;
  logic              Ctl_RegWrite, Ctl_MemRead, Ctl_MemWrite, Ctl_MemToReg, Ctl_ALUSrc, Ctl_RegDst;
  logic [3:0]        Ctl_ALUOp;
  logic              WB_RegWrite;
  logic [REG_AW-1:0] WB_DstReg;
  logic [DATA_W-1:0] WB_Data;
  logic              Flush;
  logic              ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_RegDst;
  logic [3:0]        ID_EX_ALUOp;
  logic [REG_AW-1:0] ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
  logic [DATA_W-1:0] ID_EX_Data1, ID_EX_Data2, ID_EX_Imm;
  logic              Stall;
  logic [CNT_W-1:0]  StallCount;

  int checks = 0;
  int failures = 0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_Rd(IF_ID_Rd), .IF_ID_Imm(IF_ID_Imm),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Ctl_RegWrite(Ctl_RegWrite), .Ctl_MemRead(Ctl_MemRead), .Ctl_MemWrite(Ctl_MemWrite),
    .Ctl_MemToReg(Ctl_MemToReg), .Ctl_ALUSrc(Ctl_ALUSrc), .Ctl_RegDst(Ctl_RegDst),
    .Ctl_ALUOp(Ctl_ALUOp),
    .WB_RegWrite(WB_RegWrite), .WB_DstReg(WB_DstReg), .WB_Data(WB_Data), .Flush(Flush),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_MemToReg(ID_EX_MemToReg), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_RegDst(ID_EX_RegDst),
    .ID_EX_ALUOp(ID_EX_ALUOp),
    .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_Data1(ID_EX_Data1), .ID_EX_Data2(ID_EX_Data2), .ID_EX_Imm(ID_EX_Imm),
    .Stall(Stall), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    IF_ID_Rs = '0; IF_ID_Rt = '0; IF_ID_Rd = '0; IF_ID_Imm = '0;
    ReadData1 = '0; ReadData2 = '0;
    Ctl_RegWrite = 0; Ctl_MemRead = 0; Ctl_MemWrite = 0; Ctl_MemToReg = 0;
    Ctl_ALUSrc = 0; Ctl_RegDst = 0; Ctl_ALUOp = '0;
    WB_RegWrite = 0; WB_DstReg = '0; WB_Data = '0; Flush = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a load to ID with destination rt and capture it.
  task automatic load_lw(input logic [REG_AW-1:0] rt);
    idle();
    Ctl_MemRead = 1; Ctl_RegWrite = 1; Ctl_MemToReg = 1; Ctl_ALUSrc = 1;
    IF_ID_Rs = 5'd2; IF_ID_Rt = rt; IF_ID_Imm = 16'h0004;
    cyc();
  endtask

  initial begin
    idle();
    rst_n = 0;
    cyc(); cyc();
    chk("rst_regwrite", 32'(ID_EX_RegWrite), 32'h0);
    chk("rst_data1", ID_EX_Data1, 32'h0);
    chk("rst_imm", ID_EX_Imm, 32'h0);
    chk("rst_stall", 32'(Stall), 32'h0);
    chk("rst_count", 32'(StallCount), 32'h0);
    rst_n = 1;

    // Capture some nonzero state, then reset asynchronously mid-cycle.
    Ctl_RegWrite = 1; Ctl_ALUOp = 4'hA; IF_ID_Rd = 5'd3;
    ReadData1 = 32'h11; ReadData2 = 32'h22; IF_ID_Imm = 16'h8001;
    cyc();
    chk("pre_data1", ID_EX_Data1, 32'h11);
    #3 rst_n = 0;
    #1;
    chk("async_rst_data1", ID_EX_Data1, 32'h0);
    chk("async_rst_regwrite", 32'(ID_EX_RegWrite), 32'h0);
    chk("async_rst_aluop", 32'(ID_EX_ALUOp), 32'h0);
    rst_n = 1;

    // First capture after reset.
    IF_ID_Rs = 5'd1; IF_ID_Rt = 5'd2;
    cyc();
    chk("cap_data1", ID_EX_Data1, 32'h11);
    chk("cap_data2", ID_EX_Data2, 32'h22);
    chk("cap_imm", ID_EX_Imm, 32'hFFFF8001);
    chk("cap_regwrite", 32'(ID_EX_RegWrite), 32'h1);
    chk("cap_aluop", 32'(ID_EX_ALUOp), 32'hA);
    chk("cap_rd", 32'(ID_EX_Rd), 32'h3);

    // Load-use stall.
    load_lw(5'd5);
    chk("lw_memread", 32'(ID_EX_MemRead), 32'h1);
    chk("lw_rt", 32'(ID_EX_Rt), 32'h5);
    chk("lw_imm", ID_EX_Imm, 32'h4);
    idle();
    Ctl_RegWrite = 1; IF_ID_Rs = 5'd5; IF_ID_Rt = 5'd6; IF_ID_Rd = 5'd7;
    ReadData1 = 32'h55; ReadData2 = 32'h66; IF_ID_Imm = 16'h0010;
    #1;
    chk("lu_stall", 32'(Stall), 32'h1);
    cyc();
    chk("lu_bubble_regwrite", 32'(ID_EX_RegWrite), 32'h0);
    chk("lu_bubble_memread", 32'(ID_EX_MemRead), 32'h0);
    chk("lu_bubble_data1", ID_EX_Data1, 32'h0);
    chk("lu_bubble_rt", 32'(ID_EX_Rt), 32'h0);
    chk("lu_count", 32'(StallCount), 32'h1);
    chk("lu_stall_released", 32'(Stall), 32'h0);
    cyc();
    chk("lu_after_data1", ID_EX_Data1, 32'h55);
    chk("lu_after_rd", 32'(ID_EX_Rd), 32'h7);
    chk("lu_after_count", 32'(StallCount), 32'h1);

    // Load to $zero never stalls.
    load_lw(5'd0);
    idle();
    ReadData1 = 32'h99;
    #1;
    chk("rt0_stall", 32'(Stall), 32'h0);
    cyc();
    chk("rt0_data1", ID_EX_Data1, 32'h99);
    chk("rt0_count", 32'(StallCount), 32'h1);

    // WB bypass on Rt, then $zero destination, then Rs==Rt, then WB disabled.
    idle();
    WB_RegWrite = 1; WB_DstReg = 5'd7; WB_Data = 32'hDEADBEEF;
    IF_ID_Rs = 5'd1; IF_ID_Rt = 5'd7; ReadData1 = 32'h1; ReadData2 = 32'h7;
    cyc();
    chk("byp_data2", ID_EX_Data2, 32'hDEADBEEF);
    chk("byp_data1_untouched", ID_EX_Data1, 32'h1);
    WB_DstReg = 5'd0;
    cyc();
    chk("byp_r0_data2", ID_EX_Data2, 32'h7);
    WB_DstReg = 5'd9; IF_ID_Rs = 5'd9; IF_ID_Rt = 5'd9;
    cyc();
    chk("byp_both_data1", ID_EX_Data1, 32'hDEADBEEF);
    chk("byp_both_data2", ID_EX_Data2, 32'hDEADBEEF);
    WB_RegWrite = 0;
    cyc();
    chk("byp_off_data1", ID_EX_Data1, 32'h1);

    // Flush overrides a load-use hazard and is not counted.
    load_lw(5'd5);
    idle();
    Ctl_RegWrite = 1; IF_ID_Rs = 5'd5; ReadData1 = 32'h77; Flush = 1;
    #1;
    chk("fl_stall", 32'(Stall), 32'h0);
    cyc();
    chk("fl_bubble_regwrite", 32'(ID_EX_RegWrite), 32'h0);
    chk("fl_bubble_data1", ID_EX_Data1, 32'h0);
    chk("fl_bubble_rs", 32'(ID_EX_Rs), 32'h0);
    chk("fl_count", 32'(StallCount), 32'h1);

    // Five more load-use stalls saturate the 2-bit counter at 3.
    for (int i = 0; i < 5; i++) begin
      load_lw(5'd4);
      idle();
      IF_ID_Rt = 5'd4;
      #1;
      chk("sat_stall", 32'(Stall), 32'h1);
      cyc();
      chk("sat_count", 32'(StallCount), (i == 0) ? 32'h2 : 32'h3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS core.
- Consumes the register-file read data, the IF/ID instruction fields and the decoder control word, and registers them for EX.
- Contains load-use hazard detection with bubble insertion, branch-flush bubble insertion, a WB→ID bypass and a saturating stall counter.
- Sits directly downstream of the register file and upstream of the EX/forwarding logic.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.
- IMM_W, 16, immediate width before sign extension.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- IF_ID_Rs, IF_ID_Rt, IF_ID_Rd  in  REG_AW  source and destination register fields.
- IF_ID_Imm  in  IMM_W  raw immediate.
- ReadData1, ReadData2  in  DATA_W  register-file outputs; stable before posedge because the register file reads on negedge.
- Ctl_RegWrite, Ctl_MemRead, Ctl_MemWrite, Ctl_MemToReg, Ctl_ALUSrc, Ctl_RegDst  in  1  decoder control bits.
- Ctl_ALUOp  in  4  ALU operation.
- WB_RegWrite  in  1  write-back write enable.
- WB_DstReg  in  REG_AW  write-back destination register.
- WB_Data  in  DATA_W  write-back data.
- Flush  in  1  branch/jump taken; squash the instruction in ID.
- ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_RegDst  out  1  registered control bits.
- ID_EX_ALUOp  out  4  registered ALU operation.
- ID_EX_Rs, ID_EX_Rt, ID_EX_Rd  out  REG_AW  registered register fields.
- ID_EX_Data1, ID_EX_Data2  out  DATA_W  registered operands.
- ID_EX_Imm  out  DATA_W  registered sign-extended immediate.
- Stall  out  1  combinational; holds the PC and IF/ID in the current cycle.
- StallCount  out  CNT_W  number of bubbles inserted.

Behaviour:

Reset:
- rst_n low asynchronously clears every registered output to 0.
- 0 on all registered outputs is a NOP bubble.
- Stall is therefore 0 during reset.
- Reset takes effect mid-stall or mid-flush with no residual state.

Operand bypass (combinational, before the register):
- op1 = WB_Data if WB_RegWrite && WB_DstReg != 0 && WB_DstReg == IF_ID_Rs; otherwise op1 = ReadData1.
- op2 is identical using IF_ID_Rt and ReadData2.
- Register 0 is never bypassed.

Immediate:
- ID_EX_Imm = IF_ID_Imm sign-extended from bit IMM_W-1 to DATA_W.

Hazard detection (combinational):
- Stall = ID_EX_MemRead && ID_EX_Rt != 0 && (ID_EX_Rt == IF_ID_Rs || ID_EX_Rt == IF_ID_Rt).
- Stall is forced to 0 when Flush = 1.

Per-posedge update, in priority order:
1. Flush = 1 → load a bubble: all control outputs 0, all data/field outputs 0.
2. Stall = 1 → load a bubble identically.
3. Otherwise → capture op1, op2, the immediate, IF_ID_Rs/Rt/Rd and all Ctl_* inputs.

Latency and stall duration:
- Normal path latency is 1 cycle.
- A stall lasts exactly 1 cycle, because the bubble clears ID_EX_MemRead.
- Back-to-back loads each stall once.

StallCount:
- Increments by 1 on every posedge where a bubble is loaded because Stall = 1.
- Flush bubbles are not counted.
- Saturates at 2^CNT_W-1 and does not wrap.

Simultaneous events:
- Flush and a load-use hazard in the same cycle → flush bubble only, no count.
- WB bypass during a stall cycle: irrelevant, the bubble is loaded.
- Rs == Rt with both matching WB → both operands bypassed.

Test Plan:
- Reset then idle: assert rst_n=0 mid-cycle → all outputs 0 immediately (asynchronous); release → first posedge captures Ctl_RegWrite=1, ReadData1=0x11, ReadData2=0x22, IF_ID_Imm=0x8001 → ID_EX_Data1=0x11, ID_EX_Data2=0x22, ID_EX_Imm=0xFFFF8001.
- Load-use: previous instruction lw captured with ID_EX_Rt=5, ID_EX_MemRead=1; now IF_ID_Rs=5 → Stall=1 for one cycle; next ID_EX_* all 0; StallCount=1; following cycle Stall=0 and the instruction is captured normally.
- Rt=0 load: ID_EX_MemRead=1, ID_EX_Rt=0, IF_ID_Rs=0 → Stall=0, no bubble.
- WB bypass: WB_RegWrite=1, WB_DstReg=7, WB_Data=0xDEADBEEF, IF_ID_Rt=7, ReadData2=0x7 → ID_EX_Data2=0xDEADBEEF; repeat with WB_DstReg=0 → ID_EX_Data2=ReadData2.
- Flush with hazard: Flush=1 while load-use conditions hold → Stall=0, bubble loaded, StallCount unchanged.
- Saturation: CNT_W=2, force 5 consecutive load-use stalls → StallCount reaches 3 and holds at 3.
